// File: rtl/bayer_pkg.sv
// Shared phase encodings and 8-bit conversion for the Bayer demosaic slice.
// DEMOSAIC_ROUND_EN selects half-up rounding with saturation; otherwise truncation.
package bayer_pkg;

  typedef enum logic [1:0] {
    PH_GR = 2'b00,
    PH_R  = 2'b01,
    PH_B  = 2'b10,
    PH_GB = 2'b11
  } phase_t;

  // Samples are left-aligned into ALIGN_W bits before conversion, so DATA_W may range 8..16.
  localparam int ALIGN_W = 16;
  localparam logic [ALIGN_W:0] ROUND_HALF = 17'h00080;

  function automatic logic [7:0] to8(input logic [ALIGN_W-1:0] v);
`ifdef DEMOSAIC_ROUND_EN
    logic [ALIGN_W:0] s;
    s = {1'b0, v} + ROUND_HALF;
    return s[ALIGN_W] ? 8'hFF : s[ALIGN_W-1:ALIGN_W-8];
`else
    return v[ALIGN_W-1:ALIGN_W-8];
`endif
  endfunction

endpackage

// File: rtl/bayer_line_buffer.sv
// One-line sample store: simple dual-port RAM with registered read.
// A read at the address being written returns the previously stored sample.
module bayer_line_buffer #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 1280,
  parameter int ADDR_W = 11
) (
  input  logic              iClk,
  input  logic              iWe,
  input  logic [ADDR_W-1:0] iWAddr,
  input  logic [DATA_W-1:0] iWData,
  input  logic [ADDR_W-1:0] iRAddr,
  output logic [DATA_W-1:0] oRData
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge iClk) begin
    if (iWe) mem[iWAddr] <= iWData;
    oRData <= mem[iRAddr];
  end

endmodule

// File: rtl/bayer_demosaic.sv
// Raw Bayer to 8-bit RGB using a 2x2 window, two-cycle latency on every output.
// Build option DEMOSAIC_ROUND_EN switches the 8-bit conversion to rounding.
module bayer_demosaic
  import bayer_pkg::*;
#(
  parameter int         DATA_W      = 12,
  parameter int         MAX_WIDTH   = 1280,
  parameter int         ADDR_W      = 11,
  parameter logic [1:0] BAYER_PHASE = 2'b00
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic [DATA_W-1:0] iData,
  input  logic              iDataValid,
  input  logic              iLineValid,
  input  logic              iHSync,
  input  logic              iVSync,
  output logic [7:0]        oR,
  output logic [7:0]        oG,
  output logic [7:0]        oB,
  output logic              oHSync,
  output logic              oVSync,
  output logic              oDataValid,
  output logic              oLineValid,
  output logic              oOverflow
);

  localparam int COL_W = ADDR_W + 1;
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(MAX_WIDTH);

  logic [COL_W-1:0]  col;
  logic              rowOdd, rowNz, pvPrev, lineArm;
  logic              pixValid, colInRange, ramWe;
  logic [DATA_W-1:0] ramQ;

  logic [DATA_W-1:0] s1Cur, s1CurPrev, s1PrevPrev;
  logic              s1Black, s1Ovf, s1Dv, s1Lv, s1Hs, s1Vs;
  phase_t            s1Phase;

  logic [DATA_W-1:0] rSel, bSel, g1Sel, g2Sel;
  logic [DATA_W:0]   gSum;

  // After reset, pixels are ignored until the current line has ended.
  assign pixValid   = iDataValid && lineArm;
  assign colInRange = col < COL_MAX;
  assign ramWe      = pixValid && colInRange;

  bayer_line_buffer #(
    .DATA_W(DATA_W),
    .DEPTH (MAX_WIDTH),
    .ADDR_W(ADDR_W)
  ) uLineBuf (
    .iClk  (iClk),
    .iWe   (ramWe),
    .iWAddr(col[ADDR_W-1:0]),
    .iWData(iData),
    .iRAddr(col[ADDR_W-1:0]),
    .oRData(ramQ)
  );

  function automatic logic [ALIGN_W-1:0] alignUp(input logic [DATA_W-1:0] v);
    return ALIGN_W'(v) << (ALIGN_W - DATA_W);
  endfunction

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      col     <= '0;
      rowOdd  <= 1'b0;
      rowNz   <= 1'b0;
      pvPrev  <= 1'b0;
      lineArm <= 1'b0;
    end else begin
      lineArm <= lineArm || !iDataValid;
      pvPrev  <= pixValid;
      if (!pixValid || !iLineValid) col <= '0;
      else if (colInRange)          col <= col + COL_W'(1);
      if (!iLineValid) begin
        rowOdd <= 1'b0;
        rowNz  <= 1'b0;
      end else if (pvPrev && !pixValid) begin
        rowOdd <= !rowOdd;
        rowNz  <= 1'b1;
      end
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      s1Cur      <= '0;
      s1CurPrev  <= '0;
      s1PrevPrev <= '0;
      s1Black    <= 1'b1;
      s1Ovf      <= 1'b0;
      s1Phase    <= PH_GR;
      s1Dv       <= 1'b0;
      s1Lv       <= 1'b0;
      s1Hs       <= 1'b0;
      s1Vs       <= 1'b0;
    end else begin
      s1Cur      <= iData;
      s1CurPrev  <= s1Cur;
      s1PrevPrev <= ramQ;
      s1Black    <= !pixValid || (col == '0) || !rowNz || !colInRange;
      s1Ovf      <= pixValid && !colInRange;
      s1Phase    <= phase_t'({rowOdd, col[0]} ^ BAYER_PHASE);
      s1Dv       <= iDataValid;
      s1Lv       <= iLineValid;
      s1Hs       <= iHSync;
      s1Vs       <= iVSync;
    end
  end

  // Window: ramQ = previous row at col, s1PrevPrev = previous row at col-1.
  always_comb begin
    rSel  = s1CurPrev;
    bSel  = ramQ;
    g1Sel = s1Cur;
    g2Sel = s1PrevPrev;
    case (s1Phase)
      PH_R: begin
        rSel = s1Cur;      bSel = s1PrevPrev; g1Sel = s1CurPrev; g2Sel = ramQ;
      end
      PH_B: begin
        rSel = s1PrevPrev; bSel = s1Cur;      g1Sel = s1CurPrev; g2Sel = ramQ;
      end
      PH_GB: begin
        rSel = ramQ;       bSel = s1CurPrev;  g1Sel = s1Cur;     g2Sel = s1PrevPrev;
      end
      default: ;
    endcase
    gSum = {1'b0, g1Sel} + {1'b0, g2Sel};
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      oR         <= '0;
      oG         <= '0;
      oB         <= '0;
      oHSync     <= 1'b0;
      oVSync     <= 1'b0;
      oDataValid <= 1'b0;
      oLineValid <= 1'b0;
      oOverflow  <= 1'b0;
    end else begin
      oR         <= s1Black ? 8'h00 : to8(alignUp(rSel));
      oG         <= s1Black ? 8'h00 : to8(alignUp(gSum[DATA_W:1]));
      oB         <= s1Black ? 8'h00 : to8(alignUp(bSel));
      oHSync     <= s1Hs;
      oVSync     <= s1Vs;
      oDataValid <= s1Dv;
      oLineValid <= s1Lv;
      oOverflow  <= s1Lv && (oOverflow || s1Ovf);
    end
  end

endmodule

// File: tb/tb_bayer_demosaic.sv
// Bench for bayer_demosaic: two phase variants against a position-based colour model.
module tb_bayer_demosaic;

  localparam int DW   = 12;
  localparam int MAXW = 16;
  localparam int AW   = 4;
  localparam logic [1:0] PH0 = 2'b00;
  localparam logic [1:0] PH1 = 2'b01;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic hs;
    logic vs;
    logic dv;
    logic lv;
    logic ov;
  } out_t;

  logic iClk = 1'b0;
  logic iRst = 1'b0;
  logic [DW-1:0] iData = '0;
  logic iDataValid = 1'b0, iLineValid = 1'b0, iHSync = 1'b0, iVSync = 1'b0;
  logic [7:0] r0, g0, b0, r1, g1, b1;
  logic hs0, vs0, dv0, lv0, ov0, hs1, vs1, dv1, lv1, ov1;

  always #5 iClk = ~iClk;

  bayer_demosaic #(.DATA_W(DW), .MAX_WIDTH(MAXW), .ADDR_W(AW), .BAYER_PHASE(PH0)) dut0 (
    .iClk(iClk), .iRst(iRst), .iData(iData), .iDataValid(iDataValid), .iLineValid(iLineValid),
    .iHSync(iHSync), .iVSync(iVSync), .oR(r0), .oG(g0), .oB(b0), .oHSync(hs0), .oVSync(vs0),
    .oDataValid(dv0), .oLineValid(lv0), .oOverflow(ov0));

  bayer_demosaic #(.DATA_W(DW), .MAX_WIDTH(MAXW), .ADDR_W(AW), .BAYER_PHASE(PH1)) dut1 (
    .iClk(iClk), .iRst(iRst), .iData(iData), .iDataValid(iDataValid), .iLineValid(iLineValid),
    .iHSync(iHSync), .iVSync(iVSync), .oR(r1), .oG(g1), .oB(b1), .oHSync(hs1), .oVSync(vs1),
    .oDataValid(dv1), .oLineValid(lv1), .oOverflow(ov1));

  int checks = 0;
  int errors = 0;
  int hitRgb = 0;
  int hitOvf = 0;
  logic [23:0] hitTarget = 24'h0;
  bit ctrlOnly = 1'b0;
  string tname = "init";

  // Reference model state: position in line/frame and the stored previous line.
  int mCol = 0, mRow = 0;
  bit mArm = 1'b0, mPrevPv = 1'b0, mOvf = 1'b0;
  int pend [MAXW];
  bit pendM [MAXW];
  int lastRow [MAXW];
  out_t expD1 [2];

  function automatic int to8m(input int v);
`ifdef DEMOSAIC_ROUND_EN
    int t;
    t = v + (1 << (DW - 9));
    if (t >= (1 << DW)) return 255;
    return t >> (DW - 8);
`else
    return v >> (DW - 8);
`endif
  endfunction

  // Classify each window sample by the colour at its own position.
  function automatic out_t pixExp(input logic [1:0] ph, input int r, input int c,
                                  input int cc, input int cp, input int pc, input int pp);
    int s [4];
    int rr [4];
    int cl [4];
    int rs, bs, gs;
    logic [1:0] colr;
    out_t o;
    s  = '{cc, cp, pc, pp};
    rr = '{r, r, r - 1, r - 1};
    cl = '{c, c - 1, c, c - 1};
    rs = 0; bs = 0; gs = 0;
    for (int k = 0; k < 4; k++) begin
      colr = ph ^ {rr[k][0], cl[k][0]};
      if (colr == 2'b01)      rs = s[k];
      else if (colr == 2'b10) bs = s[k];
      else                    gs += s[k];
    end
    o = '0;
    o.r = 8'(to8m(rs));
    o.g = 8'(to8m(gs / 2));
    o.b = 8'(to8m(bs));
    return o;
  endfunction

  task automatic commitLine();
    for (int i = 0; i < MAXW; i++) begin
      if (pendM[i]) lastRow[i] = pend[i];
      pendM[i] = 1'b0;
    end
  endtask

  task automatic modelStep(input logic [DW-1:0] d, input logic dv, input logic lv,
                           input logic hs, input logic vs, input logic rst,
                           output out_t e0, output out_t e1);
    bit pv, black, pixOvf;
    int c;
    e0 = '0;
    e1 = '0;
    if (!rst) begin
      commitLine();
      mCol = 0; mRow = 0; mArm = 1'b0; mPrevPv = 1'b0; mOvf = 1'b0;
      return;
    end
    pv     = dv && mArm;
    c      = mCol;
    pixOvf = pv && (c >= MAXW);
    black  = !pv || (c == 0) || (mRow == 0) || (c >= MAXW);
    if (!black) begin
      e0 = pixExp(PH0, mRow, c, int'(d), pend[c-1], lastRow[c], lastRow[c-1]);
      e1 = pixExp(PH1, mRow, c, int'(d), pend[c-1], lastRow[c], lastRow[c-1]);
    end
    if (pv && c < MAXW) begin
      pend[c]  = int'(d);
      pendM[c] = 1'b1;
    end
    mOvf = lv && (mOvf || pixOvf);
    e0.hs = hs; e0.vs = vs; e0.dv = dv; e0.lv = lv; e0.ov = mOvf;
    e1.hs = hs; e1.vs = vs; e1.dv = dv; e1.lv = lv; e1.ov = mOvf;
    if (mPrevPv && !pv) begin
      commitLine();
      mRow++;
    end
    if (!lv) mRow = 0;
    if (!pv || !lv)       mCol = 0;
    else if (mCol < MAXW) mCol++;
    if (!dv) mArm = 1'b1;
    mPrevPv = pv;
  endtask

  function automatic out_t got(input int k);
    if (k == 0) return {r0, g0, b0, hs0, vs0, dv0, lv0, ov0};
    return {r1, g1, b1, hs1, vs1, dv1, lv1, ov1};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s observed=%h expected=%h", tname, tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then check outputs for the inputs of the previous cycle.
  task automatic step(input logic [DW-1:0] d, input logic dv, input logic lv,
                      input logic hs, input logic vs);
    out_t e0, e1, o, x;
    iData = d; iDataValid = dv; iLineValid = lv; iHSync = hs; iVSync = vs;
    modelStep(d, dv, lv, hs, vs, iRst, e0, e1);
    @(posedge iClk);
    #1;
    for (int k = 0; k < 2; k++) begin
      o = got(k);
      x = iRst ? expD1[k] : '0;
      if (ctrlOnly) begin
        o.r = '0; o.g = '0; o.b = '0; o.ov = 1'b0;
        x.r = '0; x.g = '0; x.b = '0; x.ov = 1'b0;
      end
      chk(k == 0 ? "dut0" : "dut1", 32'(o), 32'(x));
    end
    o = got(0);
    if (o.dv && {o.r, o.g, o.b} == hitTarget) hitRgb++;
    if (o.dv && o.ov && {o.r, o.g, o.b} == 24'h0) hitOvf++;
    expD1[0] = e0;
    expD1[1] = e1;
  endtask

  function automatic logic [DW-1:0] sample(input int mode, input logic [DW-1:0] k,
                                           input int y, input int x);
    if (mode == 0) return k;
    if (mode == 1) begin
      case ({y[0], x[0]})
        2'b01:   return 12'hFF0;
        2'b10:   return 12'h010;
        default: return 12'h100;
      endcase
    end
    return DW'($urandom);
  endfunction

  task automatic frame(input int w, input int h, input int mode, input logic [DW-1:0] k);
    repeat (2) step('0, 0, 0, 0, 0);
    step('0, 0, 0, 0, 1);
    step('0, 0, 1, 0, 0);
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) step(sample(mode, k, y, x), 1, 1, 0, 0);
      step('0, 0, 1, 1, 0);
      step('0, 0, 1, 0, 0);
    end
    repeat (3) step('0, 0, 0, 0, 0);
  endtask

  initial begin
    expD1[0] = '0;
    expD1[1] = '0;
    repeat (3) @(posedge iClk);
    #1;
    tname = "reset";
    chk("dut0", 32'(got(0)), 32'h0);
    chk("dut1", 32'(got(1)), 32'h0);
    iRst = 1'b1;

    tname = "flat800"; hitRgb = 0; hitTarget = 24'h808080;
    frame(8, 4, 0, 12'h800);
    chk("interior_count", 32'(hitRgb), 32'd21);

    tname = "tiles"; hitRgb = 0; hitTarget = 24'hFF1001;
    frame(8, 4, 1, '0);
    chk("interior_count", 32'(hitRgb), 32'd21);

    tname = "ffs"; hitRgb = 0; hitTarget = 24'hFFFFFF;
    frame(8, 4, 0, 12'hFF8);
    chk("interior_count", 32'(hitRgb), 32'd21);

    tname = "7f8"; hitRgb = 0;
`ifdef DEMOSAIC_ROUND_EN
    hitTarget = 24'h808080;
`else
    hitTarget = 24'h7F7F7F;
`endif
    frame(8, 4, 0, 12'h7F8);
    chk("interior_count", 32'(hitRgb), 32'd21);

    tname = "overflow"; hitOvf = 0;
    frame(MAXW + 3, 3, 0, 12'h800);
    chk("black_ovf_count", 32'(hitOvf), 32'd11);

    tname = "fullwidth"; hitOvf = 0;
    frame(MAXW, 3, 2, '0);
    chk("black_ovf_count", 32'(hitOvf), 32'd0);

    tname = "ctrl_random"; ctrlOnly = 1'b1;
    for (int i = 0; i < 80; i++)
      step(DW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    step('0, 0, 0, 0, 0);
    ctrlOnly = 1'b0;

    tname = "rst_mid";
    repeat (2) step('0, 0, 0, 0, 0);
    step('0, 0, 1, 0, 0);
    for (int x = 0; x < 8; x++) step(12'h800, 1, 1, 0, 0);
    step('0, 0, 1, 1, 0);
    step('0, 0, 1, 0, 0);
    for (int x = 0; x < 4; x++) step(12'h800, 1, 1, 0, 0);
    chk("pre_reset_r", 32'(r0), 32'h80);
    iRst = 1'b0;
    #1;
    chk("async_dut0", 32'(got(0)), 32'h0);
    chk("async_dut1", 32'(got(1)), 32'h0);
    repeat (2) step(12'h800, 1, 1, 0, 0);
    iRst = 1'b1;
    repeat (2) step(12'h800, 1, 1, 0, 0);
    step('0, 0, 1, 1, 0);
    step('0, 0, 1, 0, 0);
    for (int y = 0; y < 2; y++) begin
      for (int x = 0; x < 8; x++) step(DW'($urandom), 1, 1, 0, 0);
      step('0, 0, 1, 1, 0);
      step('0, 0, 1, 0, 0);
    end
    frame(8, 4, 2, '0);

    tname = "random_frames";
    for (int i = 0; i < 3; i++)
      frame($urandom_range(2, MAXW), $urandom_range(2, 5), 2, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
